// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the move sequencer and related grid logic.
//   - FSM state enum, sequencing mode enum
//   - move encoding {is_col, idx[1:0]} widths and type
//   - grid size and LFSR feedback mask
//   - one-hot encode/decode helpers used for moves and cell enables
package move_sequencer_pkg;

    localparam int unsigned GRID_N    = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned MOVE_W    = IDX_W + 1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StFire,
        StHold,
        StGap
    } seq_state_e;

    typedef enum logic {
        ModeUser,
        ModeScramble
    } seq_mode_e;

    typedef logic [MOVE_W-1:0] move_t;

    // True when exactly one bit is set.
    function automatic logic is_onehot4(logic [GRID_N-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

    // Index of the set bit; only meaningful for one-hot input.
    function automatic logic [IDX_W-1:0] onehot_encode(logic [GRID_N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [GRID_N-1:0] idx_decode(logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [GRID_N-1:0] move_row(move_t m);
        return m[MOVE_W-1] ? '0 : idx_decode(m[IDX_W-1:0]);
    endfunction

    function automatic logic [GRID_N-1:0] move_col(move_t m);
        return m[MOVE_W-1] ? idx_decode(m[IDX_W-1:0]) : '0;
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Bundle between the move source side (user input checker / scramble request)
// and the move sequencer, plus the cell enables it drives.
//   scramble_start, user_fire, user_nrow, user_sel[3:0], user_err : toward sequencer
//   row[3:0], col[3:0], fire, busy, scramble_done                  : from sequencer
// master: the side requesting moves and consuming enables.
// slave : the move sequencer itself.
interface move_sequencer_if;
    logic       scramble_start;
    logic       user_fire;
    logic       user_nrow;
    logic [3:0] user_sel;
    logic       user_err;
    logic [3:0] row;
    logic [3:0] col;
    logic       fire;
    logic       busy;
    logic       scramble_done;

    modport master (
        output scramble_start, user_fire, user_nrow, user_sel, user_err,
        input  row, col, fire, busy, scramble_done
    );

    modport slave (
        input  scramble_start, user_fire, user_nrow, user_sel, user_err,
        output row, col, fire, busy, scramble_done
    );
endinterface

// File: rtl/move_sequencer_lfsr16.sv
// 16-bit Galois LFSR, free running (steps every cycle, never stalls).
//   clk   : clock
//   reset : asynchronous active-high reset, loads the seed
//   seed  : reset value; zero is replaced by 16'h0001 so the state never locks up
//   q     : current LFSR state
module move_sequencer_lfsr16
    import move_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_eff;
    logic [15:0] state_q;
    logic [15:0] state_d;

    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

    always_comb begin
        state_d = {1'b0, state_q[15:1]};
        if (state_q[0]) begin
            state_d = state_d ^ LFSR_MASK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= seed_eff;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/move_sequencer.sv
// Sequences every move applied to the 4x4 cell grid. Arbitrates between a
// validated user move and an internal pseudo-random scramble run, and drives
// one-hot row/col enables with one cycle of setup before fire and one of hold.
//   clk, reset : clock, asynchronous active-high reset
//   seq        : slave side of move_sequencer_if
//                (requests in; row/col/fire/busy/scramble_done out, all registered)
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int unsigned N_MOVES    = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    move_sequencer_if.slave  seq
);

    seq_state_e  state_q;
    seq_mode_e   mode_q;
    move_t       move_q;
    logic [7:0]  remaining_q;
    logic [7:0]  gap_cnt_q;
    logic [3:0]  row_q;
    logic [3:0]  col_q;
    logic        fire_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] lfsr_q;
    logic        unused_lfsr;
    move_t       next_move;
    move_t       user_move;
    logic        user_ok;

    move_sequencer_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:3];

    // A repeated move would undo itself, so bump the candidate past the previous one.
    always_comb begin
        next_move = lfsr_q[2:0];
        if (next_move == move_q) begin
            next_move = move_q + 3'd1;
        end
    end

    assign user_ok   = seq.user_fire && !seq.user_err && is_onehot4(seq.user_sel);
    assign user_move = {seq.user_nrow, onehot_encode(seq.user_sel)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= ModeUser;
            move_q      <= '0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            fire_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Scramble has priority; a coincident user strobe is dropped.
                    if (seq.scramble_start) begin
                        mode_q      <= ModeScramble;
                        remaining_q <= 8'(N_MOVES);
                        move_q      <= lfsr_q[2:0];
                        row_q       <= move_row(lfsr_q[2:0]);
                        col_q       <= move_col(lfsr_q[2:0]);
                        busy_q      <= 1'b1;
                        state_q     <= StSel;
                    end else if (user_ok) begin
                        mode_q  <= ModeUser;
                        move_q  <= user_move;
                        row_q   <= move_row(user_move);
                        col_q   <= move_col(user_move);
                        busy_q  <= 1'b1;
                        state_q <= StSel;
                    end
                end
                StSel: begin
                    fire_q  <= 1'b1;
                    state_q <= StFire;
                end
                StFire: begin
                    state_q <= StHold;
                end
                StHold: begin
                    if (mode_q == ModeUser) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        remaining_q <= remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            row_q   <= '0;
                            col_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else if (GAP_CYCLES > 0) begin
                            row_q     <= '0;
                            col_q     <= '0;
                            gap_cnt_q <= 8'(GAP_CYCLES - 1);
                            state_q   <= StGap;
                        end else begin
                            move_q  <= next_move;
                            row_q   <= move_row(next_move);
                            col_q   <= move_col(next_move);
                            state_q <= StSel;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 8'd0) begin
                        move_q  <= next_move;
                        row_q   <= move_row(next_move);
                        col_q   <= move_col(next_move);
                        state_q <= StSel;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    row_q   <= '0;
                    col_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign seq.row           = row_q;
    assign seq.col           = col_q;
    assign seq.fire          = fire_q;
    assign seq.busy          = busy_q;
    assign seq.scramble_done = done_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: user moves, rejected user strobes,
// a 3-move scramble with gaps, mid-move reset with replay, and a single
// gapless scramble move on a second instance.
module tb_move_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic [15:0] m_lfsr;
    logic [8:0]  moves1;
    logic [8:0]  moves3;

    move_sequencer_if ifa ();
    move_sequencer_if ifb ();

    move_sequencer #(
        .N_MOVES    (3),
        .GAP_CYCLES (2),
        .LFSR_SEED  (16'hACE1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .seq   (ifa)
    );

    move_sequencer #(
        .N_MOVES    (1),
        .GAP_CYCLES (0),
        .LFSR_SEED  (16'hACE1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .seq   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR alongside the DUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= lfsr_next(m_lfsr);
        end
    end

    // Expected {row, col} for a move {is_col, idx}.
    function automatic logic [7:0] exp_rc(logic [2:0] m);
        logic [3:0] oh;
        oh = 4'b0001 << m[1:0];
        return m[2] ? {4'b0000, oh} : {oh, 4'b0000};
    endfunction

    function automatic logic [1:0] enc(logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 3-move scramble on dut_a, started together with a user strobe that must lose.
    task automatic scramble_a_run(input string name, output logic [8:0] obs);
        logic [15:0] v;
        logic [2:0]  em [3];
        logic [2:0]  om [3];
        int          k;
        int          p;
        v     = m_lfsr;
        em[0] = v[2:0];
        for (int i = 1; i < 3; i++) begin
            repeat (5) v = lfsr_next(v);
            em[i] = (v[2:0] == em[i-1]) ? em[i-1] + 3'd1 : v[2:0];
        end
        for (int i = 0; i < 3; i++) om[i] = '0;
        ifa.scramble_start = 1'b1;
        ifa.user_fire      = 1'b1;
        ifa.user_sel       = 4'b0001;
        ifa.user_nrow      = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1 || c == 5 || c == 8) begin
                ifa.scramble_start = 1'b0;
                ifa.user_fire      = 1'b0;
            end else if (c == 4 || c == 7) begin
                ifa.user_fire = 1'b1;
                ifa.user_sel  = 4'b0010;
            end
            k = (c - 1) / 5;
            p = (c - 1) % 5;
            check($sformatf("%s rowcol c%0d", name, c), {ifa.row, ifa.col},
                  (c <= 13 && p <= 2) ? exp_rc(em[k]) : 8'h00);
            check($sformatf("%s fire c%0d", name, c), ifa.fire, (c <= 13 && p == 1));
            check($sformatf("%s busy c%0d", name, c), ifa.busy, (c <= 13));
            check($sformatf("%s done c%0d", name, c), ifa.scramble_done, (c == 14));
            if (c <= 13 && p == 1) begin
                om[k] = {|ifa.col, enc((|ifa.col) ? ifa.col : ifa.row)};
            end
        end
        check({name, " distinct 0-1"}, (om[1] == om[0]), 1'b0);
        check({name, " distinct 1-2"}, (om[2] == om[1]), 1'b0);
        obs = {om[2], om[1], om[0]};
    endtask

    task automatic user_move(input string name, input logic nrow, input logic [3:0] sel,
                             input logic [7:0] rc);
        ifa.user_nrow = nrow;
        ifa.user_sel  = sel;
        ifa.user_err  = 1'b0;
        ifa.user_fire = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                ifa.user_fire = 1'b0;
                ifa.user_nrow = ~nrow;     // late switch changes must not leak in
                ifa.user_sel  = 4'b1000;
            end
            check($sformatf("%s rowcol c%0d", name, c), {ifa.row, ifa.col},
                  (c <= 3) ? rc : 8'h00);
            check($sformatf("%s fire c%0d", name, c), ifa.fire, (c == 2));
            check($sformatf("%s busy c%0d", name, c), ifa.busy, (c <= 3));
        end
    endtask

    task automatic user_bad(input string name, input logic [3:0] sel, input logic err);
        ifa.user_nrow = 1'b0;
        ifa.user_sel  = sel;
        ifa.user_err  = err;
        ifa.user_fire = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            ifa.user_fire = 1'b0;
            check($sformatf("%s rowcol c%0d", name, c), {ifa.row, ifa.col}, 8'h00);
            check($sformatf("%s fire c%0d", name, c), ifa.fire, 1'b0);
            check($sformatf("%s busy c%0d", name, c), ifa.busy, 1'b0);
        end
        ifa.user_err = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        ifa.scramble_start = 1'b0;
        ifa.user_fire      = 1'b0;
        ifa.user_nrow      = 1'b0;
        ifa.user_sel       = 4'b0000;
        ifa.user_err       = 1'b0;
        ifb.scramble_start = 1'b0;
        ifb.user_fire      = 1'b0;
        ifb.user_nrow      = 1'b0;
        ifb.user_sel       = 4'b0000;
        ifb.user_err       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset rowcol", {ifa.row, ifa.col}, 8'h00);
        check("reset fire", ifa.fire, 1'b0);
        check("reset busy", ifa.busy, 1'b0);
        check("reset done", ifa.scramble_done, 1'b0);
        check("reset b busy", ifb.busy, 1'b0);

        repeat (3) tick();
        scramble_a_run("run1", moves1);

        tick();
        user_move("user row2", 1'b0, 4'b0100, 8'b0100_0000);
        user_move("user col0", 1'b1, 4'b0001, 8'b0000_0001);
        user_bad("bad sel0110", 4'b0110, 1'b0);
        user_bad("bad err", 4'b0010, 1'b1);
        user_bad("bad sel0", 4'b0000, 1'b0);

        // Abort a scramble during the fire of its second move.
        ifa.scramble_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            ifa.scramble_start = 1'b0;
        end
        check("abort fire before reset", ifa.fire, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("abort rowcol async", {ifa.row, ifa.col}, 8'h00);
        check("abort fire async", ifa.fire, 1'b0);
        check("abort busy async", ifa.busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort lfsr seed", dut_a.lfsr_q, 16'hACE1);
        check("abort idle", ifa.busy, 1'b0);

        repeat (3) tick();
        scramble_a_run("run3", moves3);
        check("replay moves", moves3, moves1);

        // Single gapless move on dut_b.
        tick();
        v = m_lfsr;
        ifb.scramble_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            ifb.scramble_start = 1'b0;
            check($sformatf("b rowcol c%0d", c), {ifb.row, ifb.col},
                  (c <= 3) ? exp_rc(v[2:0]) : 8'h00);
            check($sformatf("b fire c%0d", c), ifb.fire, (c == 2));
            check($sformatf("b busy c%0d", c), ifb.busy, (c <= 3));
            check($sformatf("b done c%0d", c), ifb.scramble_done, (c == 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Sequences all moves applied to the 4x4 cell grid.
- Arbitrates between user moves (debounced, edge-detected fire plus row/column switches) and an internal pseudo-random scramble generator.
- Drives the shared one-hot row/col enables and a single fire strobe into the x cells, with one cycle of selection setup before fire and one cycle of hold after it.
- Replaces the ad-hoc combinational row/col select in the top level; the display consumes row/col for cursor highlighting.

Parameters:
- N_MOVES, 16: number of scramble moves per scramble run (1..255).
- GAP_CYCLES, 4: idle cycles between scramble moves (0..255; 0 means no gap state).
- LFSR_SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- scramble_start  input  1  single-cycle request to start a scramble run.
- user_fire  input  1  single-cycle user move strobe (already debounced and edge-detected).
- user_nrow  input  1  0 = apply user_sel as a row, 1 = as a column.
- user_sel  input  4  user row/column select, one-hot expected.
- user_err  input  1  switch error flag from the input checker.
- row  output  4  one-hot row enable to the cells.
- col  output  4  one-hot column enable to the cells.
- fire  output  1  single-cycle fire strobe to the cells.
- busy  output  1  high whenever the FSM is not in IDLE.
- scramble_done  output  1  single-cycle pulse when the final scramble move completes.

Behaviour:
- Reset: asynchronous, active-high. On reset all outputs go to 0, the FSM goes to IDLE, move counters clear and the LFSR loads the seed. Reset asserted mid-operation aborts the move at once; any partial move is discarded.
- Registers: all outputs are registered. row/col are 0 except in the SEL, FIRE and HOLD states. Exactly one of row and col is nonzero in those states.
- Move encoding: 3 bits, {is_col, idx[1:0]}. Decode: is_col=0 gives row = 1<<idx, col = 0. is_col=1 gives col = 1<<idx, row = 0.
- FSM states: IDLE, SEL, FIRE, HOLD, GAP.
- IDLE, scramble_start=1:
  - Latch mode = SCRAMBLE and remaining = N_MOVES.
  - Take the move from LFSR[2:0].
  - Go to SEL.
- IDLE, user_fire=1, no scramble_start:
  - Accepted only if user_err=0 and user_sel is exactly one-hot. Otherwise the strobe is ignored and the FSM stays in IDLE.
  - On accept: latch mode = USER and move = {user_nrow, encode(user_sel)}, then go to SEL.
- Simultaneous scramble_start and user_fire in IDLE: scramble wins and the user strobe is dropped.
- SEL -> FIRE -> HOLD, one cycle each. row/col are held constant across all three states. fire=1 only in FIRE.
- HOLD, mode USER: go to IDLE.
- HOLD, mode SCRAMBLE:
  - Decrement remaining.
  - If remaining reaches 0: assert scramble_done for one cycle (coincident with the IDLE entry cycle) and go to IDLE.
  - Else if GAP_CYCLES > 0: go to GAP.
  - Else: go to SEL with the next move.
- GAP: row/col = 0. Count GAP_CYCLES cycles, then go to SEL with the next move.
- Next-move rule: candidate = LFSR[2:0] sampled on the cycle before SEL. If the candidate equals the previous scramble move, use candidate+1 mod 8 instead, since a repeated move cancels itself. The first move of a run has no previous move.
- LFSR: 16-bit Galois, mask 16'hB400, steps every cycle, never stalls, never zero.
- Inputs while busy: scramble_start and user_fire are ignored with no queueing. user_sel/user_nrow changes after SEL do not affect the current move.
- Latency:
  - User move: user_fire at cycle T gives row/col valid from T+1 to T+3, fire at T+2, IDLE at T+4.
  - Scramble run: total length = N_MOVES*3 + (N_MOVES-1)*GAP_CYCLES + 1 cycles from start to IDLE.

Decomposition:
- Shared package game_pkg: the state enum (IDLE, SEL, FIRE, HOLD, GAP), the move encoding widths, GRID_N=4, LFSR_MASK.
- Sub-module lfsr16 (clk, reset, seed, q[15:0]), reusable by other random features.
- The one-hot encode/decode helpers live as package functions.

Test Plan:
- User row move: user_nrow=0, user_sel=4'b0100, user_fire at T → row=0100, col=0 from T+1 to T+3; fire=1 only at T+2; busy=0 at T+4.
- Invalid user input: user_sel=4'b0110, or user_err=1, with user_fire → no fire, busy stays 0, row=col=0.
- Scramble with N_MOVES=3, GAP_CYCLES=2 → exactly 3 fire pulses spaced 5 cycles apart; scramble_done at start+14; no two consecutive moves equal; exactly one of row/col nonzero only in SEL/FIRE/HOLD.
- Simultaneous scramble_start and user_fire in IDLE → scramble runs; the user move never appears; user_fire during busy → ignored.
- Reset asserted during FIRE of move 2 → outputs 0 asynchronously; after release, the FSM is in IDLE and the LFSR equals LFSR_SEED; a new scramble replays the identical move sequence.
- GAP_CYCLES=0, N_MOVES=1 → SEL, FIRE, HOLD, then IDLE; scramble_done at start+4; busy high for 3 cycles.
